// File: rtl/cache_controller.sv
// Sequencing FSM for a 4-way, 1024-set write-through, no-write-allocate cache.
// Drives tag/data read and write enables, LFU updates, RAM line fill and word write-through.
module cache_controller #(
   parameter int ADDR_W = 48,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetGeneral,
   input  logic              run,
   input  logic              RW,
   input  logic [ADDR_W-1:0] address,
   output logic              busy,
   output logic              done,
   input  logic              hit,
   input  logic [1:0]        hit_way,
   input  logic [1:0]        victim_way,
   output logic              lfu_update,
   output logic [1:0]        lfu_way,
   output logic              ReadEnableTag,
   output logic              ReadEnableData,
   output logic              SelecMemCPU,
   output logic [3:0]        WriteEnableTag,
   output logic [3:0]        WriteEnableData,
   output logic              validBit,
   output logic              mem_req,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_TAG_RD, S_COMPARE, S_WR_HIT, S_MEM_RD, S_FILL, S_MEM_WR, S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_nextState;
   logic                r_rw;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_replay;
   logic [1:0]          r_hitWay;
   logic [1:0]          r_victim;
   logic [CNT_W-1:0]    r_hitCount;
   logic [CNT_W-1:0]    r_missCount;
   logic                r_err;

   always_ff @(posedge clk or negedge resetGeneral) begin
      if (!resetGeneral) r_state <= S_IDLE;
      else               r_state <= w_nextState;
   end

   // replay marks the second lookup after a fill, so it neither recounts nor refills
   always_ff @(posedge clk or negedge resetGeneral) begin
      if (!resetGeneral) begin
         r_rw        <= 1'b0;
         r_addr      <= '0;
         r_replay    <= 1'b0;
         r_hitWay    <= 2'd0;
         r_victim    <= 2'd0;
         r_hitCount  <= '0;
         r_missCount <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (run) begin
               r_rw     <= RW;
               r_addr   <= address;
               r_replay <= 1'b0;
            end
            S_COMPARE: begin
               r_hitWay <= hit_way;
               r_victim <= victim_way;
               if (!r_replay) begin
                  if (hit && r_hitCount != '1)        r_hitCount  <= r_hitCount + CNT_W'(1);
                  else if (!hit && r_missCount != '1) r_missCount <= r_missCount + CNT_W'(1);
               end
               if (!hit && !r_rw && r_replay) r_err <= 1'b1;
            end
            S_FILL: r_replay <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_nextState     = r_state;
      done            = 1'b0;
      lfu_update      = 1'b0;
      lfu_way         = 2'd0;
      ReadEnableTag   = 1'b0;
      ReadEnableData  = 1'b0;
      SelecMemCPU     = 1'b0;
      WriteEnableTag  = 4'b0000;
      WriteEnableData = 4'b0000;
      validBit        = 1'b0;
      mem_req         = 1'b0;
      mem_rw          = 1'b0;
      mem_addr        = '0;
      case (r_state)
         S_IDLE: if (run) w_nextState = S_TAG_RD;
         S_TAG_RD: begin
            ReadEnableTag  = 1'b1;
            ReadEnableData = 1'b1;
            w_nextState    = S_COMPARE;
         end
         S_COMPARE: begin
            if (hit) begin
               lfu_update  = 1'b1;
               lfu_way     = hit_way;
               w_nextState = r_rw ? S_WR_HIT : S_DONE;
            end else if (r_rw) begin
               w_nextState = S_MEM_WR;
            end else begin
               w_nextState = r_replay ? S_DONE : S_MEM_RD;
            end
         end
         S_WR_HIT: begin
            WriteEnableData = 4'b0001 << r_hitWay;
            w_nextState     = S_MEM_WR;
         end
         S_MEM_RD: begin
            mem_req  = 1'b1;
            mem_addr = {r_addr[ADDR_W-1:2], 2'b00};
            if (mem_ack) w_nextState = S_FILL;
         end
         S_FILL: begin
            SelecMemCPU     = 1'b1;
            validBit        = 1'b1;
            WriteEnableTag  = 4'b0001 << r_victim;
            WriteEnableData = 4'b0001 << r_victim;
            w_nextState     = S_TAG_RD;
         end
         S_MEM_WR: begin
            mem_req  = 1'b1;
            mem_rw   = 1'b1;
            mem_addr = r_addr;
            if (mem_ack) w_nextState = S_DONE;
         end
         S_DONE: begin
            done        = 1'b1;
            w_nextState = S_IDLE;
         end
         default: w_nextState = S_IDLE;
      endcase
   end

   assign busy       = (r_state != S_IDLE);
   assign hit_count  = r_hitCount;
   assign miss_count = r_missCount;
   assign err        = r_err;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus randomized accesses
// checked against a timeline-level reference model.
module tb_cache_controller;

   localparam int ADDR_W = 48;
   localparam int CNT_W  = 4;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              resetGeneral = 1'b0;
   logic              run = 1'b0;
   logic              RW = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic              busy, done;
   logic              hit = 1'b0;
   logic [1:0]        hit_way = 2'd0;
   logic [1:0]        victim_way = 2'd0;
   logic              lfu_update;
   logic [1:0]        lfu_way;
   logic              ReadEnableTag, ReadEnableData, SelecMemCPU;
   logic [3:0]        WriteEnableTag, WriteEnableData;
   logic              validBit, mem_req, mem_rw;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack = 1'b0;
   logic [CNT_W-1:0]  hit_count, miss_count;
   logic              err;

   cache_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .resetGeneral(resetGeneral), .run(run), .RW(RW), .address(address),
      .busy(busy), .done(done), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
      .lfu_update(lfu_update), .lfu_way(lfu_way), .ReadEnableTag(ReadEnableTag),
      .ReadEnableData(ReadEnableData), .SelecMemCPU(SelecMemCPU),
      .WriteEnableTag(WriteEnableTag), .WriteEnableData(WriteEnableData),
      .validBit(validBit), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // observations gathered by runAccess, one access at a time
   int                obsDoneCnt, obsDoneCyc, obsLfuCnt, obsLfuCyc, obsWeCnt, obsWeCyc;
   int                obsWeMulti, obsReqCyc, obsAckCyc, obsReCnt, obsBusyBad;
   logic [1:0]        obsLfuWay;
   logic [3:0]        obsWeData, obsWeTag;
   logic              obsWeSel, obsWeValid, obsMemRw;
   logic [ADDR_W-1:0] obsMemAddr;

   // reference model: expected hit/miss/err bookkeeping and access timeline
   int                expHits, expMiss;
   bit                expErr;
   int                expDoneCyc, expLfuCnt, expWeCnt, expReqCyc, expReCnt;
   logic [1:0]        expLfuWay;
   logic [3:0]        expWeData, expWeTag;
   logic              expWeSel, expMemRw;
   logic [ADDR_W-1:0] expMemAddr;

   task automatic modelAccess(input logic rw, input logic [ADDR_W-1:0] addr, input logic hitFirst,
                              input logic replayHit, input logic [1:0] hw, input logic [1:0] vw,
                              input int k);
      expLfuWay  = hw;
      expWeData  = 4'b0000;
      expWeTag   = 4'b0000;
      expWeSel   = 1'b0;
      expWeCnt   = 0;
      expReqCyc  = 0;
      expReCnt   = 1;
      expLfuCnt  = 0;
      expMemRw   = rw;
      expMemAddr = rw ? addr : (addr & ~48'h3);
      if (hitFirst) expHits = (expHits < CMAX) ? expHits + 1 : CMAX;
      else          expMiss = (expMiss < CMAX) ? expMiss + 1 : CMAX;
      if (!rw && hitFirst) begin
         expDoneCyc = 3;
         expLfuCnt  = 1;
      end else if (!rw) begin
         expReqCyc  = k;
         expWeCnt   = 1;
         expWeData  = 4'(1 << vw);
         expWeTag   = 4'(1 << vw);
         expWeSel   = 1'b1;
         expReCnt   = 2;
         expDoneCyc = 6 + k;
         expLfuCnt  = replayHit ? 1 : 0;
         if (!replayHit) expErr = 1'b1;
      end else if (hitFirst) begin
         expWeCnt   = 1;
         expWeData  = 4'(1 << hw);
         expReqCyc  = k;
         expDoneCyc = 4 + k;
         expLfuCnt  = 1;
      end else begin
         expReqCyc  = k;
         expDoneCyc = 3 + k;
      end
   endtask

   // acts as CPU, hit logic and RAM for one access; hit switches to replayHit after the fill
   task automatic runAccess(input logic rw, input logic [ADDR_W-1:0] addr, input logic hitFirst,
                            input logic replayHit, input logic [1:0] hw, input logic [1:0] vw,
                            input int k, input bit pulseBusy);
      int reqN = 0;
      bit fillSeen = 0;
      obsDoneCnt = 0; obsDoneCyc = -1; obsLfuCnt = 0; obsLfuCyc = -1; obsWeCnt = 0;
      obsWeCyc = -1; obsWeMulti = 0; obsReqCyc = 0; obsAckCyc = -1; obsReCnt = 0;
      obsBusyBad = 0; obsLfuWay = 2'd0; obsWeData = 4'b0; obsWeTag = 4'b0; obsWeSel = 1'b0;
      obsWeValid = 1'b0; obsMemRw = 1'b0; obsMemAddr = '0;
      @(negedge clk);
      RW = rw; address = addr; hit = hitFirst; hit_way = hw; victim_way = vw;
      mem_ack = 1'b0; run = 1'b1;
      for (int c = 1; c <= 200 && !(obsDoneCnt > 0 && c > obsDoneCyc + 2); c++) begin
         @(negedge clk);
         run = pulseBusy && (c <= 2);
         if (done) begin
            if (obsDoneCnt == 0) obsDoneCyc = c;
            obsDoneCnt++;
         end
         if (busy !== (obsDoneCnt == 0 || c <= obsDoneCyc)) obsBusyBad++;
         if (lfu_update) begin obsLfuCnt++; obsLfuWay = lfu_way; obsLfuCyc = c; end
         if (ReadEnableTag && ReadEnableData) obsReCnt++;
         if (WriteEnableData != 4'b0 || WriteEnableTag != 4'b0) begin
            obsWeCnt++;
            obsWeData = WriteEnableData; obsWeTag = WriteEnableTag;
            obsWeSel = SelecMemCPU; obsWeValid = validBit; obsWeCyc = c;
            if ($countones(WriteEnableData) > 1 || $countones(WriteEnableTag) > 1) obsWeMulti++;
         end
         if (mem_req) begin
            reqN++;
            obsReqCyc++;
            obsMemAddr = mem_addr;
            obsMemRw = mem_rw;
            mem_ack = (reqN == k);
            if (reqN == k) obsAckCyc = c;
         end else begin
            mem_ack = 1'b0;
         end
         if (WriteEnableTag != 4'b0 && !fillSeen) begin
            fillSeen = 1;
            hit = replayHit;
         end
      end
      mem_ack = 1'b0;
      run = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      resetGeneral = 1'b0; run = 1'b0; mem_ack = 1'b0; hit = 1'b0;
      #13;
      @(negedge clk);
      resetGeneral = 1'b1;
      expHits = 0; expMiss = 0; expErr = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      resetGeneral = 1'b0;
      #2;
      checks++;
      if ({busy, done, mem_req, err, lfu_update} !== 5'b0 || hit_count !== 4'd0 || miss_count !== 4'd0
          || WriteEnableTag !== 4'b0 || WriteEnableData !== 4'b0) begin
         errors++;
         $display("[TB] FAIL reset_state busy=%b done=%b req=%b err=%b hc=%0d mc=%0d wet=%b wed=%b exp all 0",
                  busy, done, mem_req, err, hit_count, miss_count, WriteEnableTag, WriteEnableData);
      end
      doReset();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle busy=%b exp 0", busy); end
   endtask

   task automatic test_read_hit();
      doReset();
      runAccess(1'b0, 48'h0000_0000_1004, 1'b1, 1'b1, 2'd2, 2'd0, 1, 1'b0);
      checks++;
      if (obsDoneCyc !== 3 || obsDoneCnt !== 1) begin
         errors++; $display("[TB] FAIL rd_hit_done cyc=%0d cnt=%0d exp cyc=3 cnt=1", obsDoneCyc, obsDoneCnt);
      end
      checks++;
      if (obsLfuCyc !== 2 || obsLfuWay !== 2'd2 || obsLfuCnt !== 1) begin
         errors++; $display("[TB] FAIL rd_hit_lfu cyc=%0d way=%0d cnt=%0d exp 2/2/1", obsLfuCyc, obsLfuWay, obsLfuCnt);
      end
      checks++;
      if (hit_count !== 4'd1 || obsWeCnt !== 0 || obsReqCyc !== 0) begin
         errors++; $display("[TB] FAIL rd_hit_side hc=%0d we=%0d req=%0d exp 1/0/0", hit_count, obsWeCnt, obsReqCyc);
      end
   endtask

   task automatic test_read_miss();
      doReset();
      runAccess(1'b0, 48'h0000_0000_1004, 1'b0, 1'b1, 2'd0, 2'd3, 2, 1'b0);
      checks++;
      if (obsMemAddr !== 48'h0000_0000_1004 || obsMemRw !== 1'b0 || obsReqCyc !== 2) begin
         errors++; $display("[TB] FAIL rd_miss_mem addr=%h rw=%b cyc=%0d exp 1004/0/2", obsMemAddr, obsMemRw, obsReqCyc);
      end
      checks++;
      if (obsWeTag !== 4'b1000 || obsWeData !== 4'b1000 || obsWeSel !== 1'b1 || obsWeValid !== 1'b1
          || obsWeCyc !== obsAckCyc + 1) begin
         errors++; $display("[TB] FAIL rd_miss_fill wet=%b wed=%b sel=%b v=%b cyc=%0d exp 1000/1000/1/1/%0d",
                            obsWeTag, obsWeData, obsWeSel, obsWeValid, obsWeCyc, obsAckCyc + 1);
      end
      checks++;
      if (obsDoneCnt !== 1 || obsDoneCyc !== obsWeCyc + 3 || obsLfuCnt !== 1 || obsReCnt !== 2) begin
         errors++; $display("[TB] FAIL rd_miss_replay done=%0d@%0d lfu=%0d re=%0d exp 1@%0d/1/2",
                            obsDoneCnt, obsDoneCyc, obsLfuCnt, obsReCnt, obsWeCyc + 3);
      end
      checks++;
      if (miss_count !== 4'd1 || hit_count !== 4'd0 || err !== 1'b0) begin
         errors++; $display("[TB] FAIL rd_miss_cnt mc=%0d hc=%0d err=%b exp 1/0/0", miss_count, hit_count, err);
      end
   endtask

   task automatic test_write_hit();
      doReset();
      runAccess(1'b1, 48'h0ABC_DEF0_1237, 1'b1, 1'b1, 2'd1, 2'd3, 1, 1'b0);
      checks++;
      if (obsWeData !== 4'b0010 || obsWeTag !== 4'b0000 || obsWeSel !== 1'b0 || obsWeCnt !== 1 || obsWeCyc !== 3) begin
         errors++; $display("[TB] FAIL wr_hit_we wed=%b wet=%b sel=%b cnt=%0d cyc=%0d exp 0010/0000/0/1/3",
                            obsWeData, obsWeTag, obsWeSel, obsWeCnt, obsWeCyc);
      end
      checks++;
      if (obsMemRw !== 1'b1 || obsMemAddr !== 48'h0ABC_DEF0_1237 || obsReqCyc !== 1 || obsDoneCyc !== 5) begin
         errors++; $display("[TB] FAIL wr_hit_mem rw=%b addr=%h req=%0d done=%0d exp 1/0abcdef01237/1/5",
                            obsMemRw, obsMemAddr, obsReqCyc, obsDoneCyc);
      end
   endtask

   task automatic test_write_miss();
      doReset();
      runAccess(1'b1, 48'h0000_0000_2002, 1'b0, 1'b0, 2'd0, 2'd2, 3, 1'b0);
      checks++;
      if (obsWeCnt !== 0 || obsReqCyc !== 3 || obsMemRw !== 1'b1 || obsMemAddr !== 48'h2002 || obsDoneCyc !== 6) begin
         errors++; $display("[TB] FAIL wr_miss we=%0d req=%0d rw=%b addr=%h done=%0d exp 0/3/1/2002/6",
                            obsWeCnt, obsReqCyc, obsMemRw, obsMemAddr, obsDoneCyc);
      end
      checks++;
      if (miss_count !== 4'd1 || obsLfuCnt !== 0) begin
         errors++; $display("[TB] FAIL wr_miss_cnt mc=%0d lfu=%0d exp 1/0", miss_count, obsLfuCnt);
      end
   endtask

   task automatic test_replay_err();
      doReset();
      runAccess(1'b0, 48'h0000_0000_3000, 1'b0, 1'b0, 2'd1, 2'd1, 1, 1'b0);
      checks++;
      if (err !== 1'b1 || obsLfuCnt !== 0 || obsDoneCnt !== 1) begin
         errors++; $display("[TB] FAIL replay_err err=%b lfu=%0d done=%0d exp 1/0/1", err, obsLfuCnt, obsDoneCnt);
      end
      runAccess(1'b0, 48'h0000_0000_3000, 1'b1, 1'b1, 2'd1, 2'd1, 1, 1'b0);
      checks++;
      if (err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky err=%b exp 1", err); end
   endtask

   task automatic test_reset_in_memrd();
      bit seen = 0;
      doReset();
      @(negedge clk);
      RW = 1'b0; address = 48'h5551; hit = 1'b0; victim_way = 2'd1; mem_ack = 1'b0; run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (mem_req) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("[TB] FAIL memrd_reach mem_req never rose, exp 1"); end
      #2 resetGeneral = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("[TB] FAIL async_reset mem_req=%b busy=%b exp 0/0", mem_req, busy);
      end
      @(negedge clk);
      resetGeneral = 1'b1;
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || miss_count !== 4'd0 || WriteEnableTag !== 4'b0) begin
         errors++; $display("[TB] FAIL stray_ack busy=%b done=%b req=%b mc=%0d wet=%b exp 0/0/0/0/0",
                            busy, done, mem_req, miss_count, WriteEnableTag);
      end
      expHits = 0; expMiss = 0; expErr = 1'b0;
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 0; i < CMAX - 1; i++)
         runAccess(1'b0, 48'(i * 4), 1'b1, 1'b1, 2'd0, 2'd0, 1, 1'b0);
      checks++;
      if (hit_count !== 4'(CMAX - 1)) begin
         errors++; $display("[TB] FAIL sat_preload hc=%0d exp %0d", hit_count, CMAX - 1);
      end
      for (int i = 0; i < 3; i++) begin
         runAccess(1'b0, 48'h40, 1'b1, 1'b1, 2'd3, 2'd0, 1, 1'b1);
         checks++;
         if (hit_count !== 4'(CMAX) || obsDoneCnt !== 1 || obsBusyBad !== 0) begin
            errors++; $display("[TB] FAIL sat_hit%0d hc=%0d done=%0d busybad=%0d exp %0d/1/0",
                               i, hit_count, obsDoneCnt, obsBusyBad, CMAX);
         end
      end
   endtask

   task automatic test_random();
      doReset();
      for (int i = 0; i < 40; i++) begin
         logic              rw, h1, h2;
         logic [1:0]        hw, vw;
         logic [ADDR_W-1:0] a;
         int                k;
         rw = 1'($urandom); h1 = 1'($urandom); h2 = ($urandom_range(0, 7) != 0);
         hw = 2'($urandom); vw = 2'($urandom); k = $urandom_range(1, 4);
         a  = {16'($urandom), 32'($urandom)};
         modelAccess(rw, a, h1, h2, hw, vw, k);
         runAccess(rw, a, h1, h2, hw, vw, k, 1'($urandom));
         checks++;
         if (obsDoneCnt !== 1 || obsDoneCyc !== expDoneCyc) begin
            errors++; $display("[TB] FAIL rand%0d_done cnt=%0d cyc=%0d exp 1/%0d", i, obsDoneCnt, obsDoneCyc, expDoneCyc);
         end
         checks++;
         if (obsLfuCnt !== expLfuCnt || (expLfuCnt == 1 && obsLfuWay !== expLfuWay)) begin
            errors++; $display("[TB] FAIL rand%0d_lfu cnt=%0d way=%0d exp %0d/%0d", i, obsLfuCnt, obsLfuWay, expLfuCnt, expLfuWay);
         end
         checks++;
         if (obsWeCnt !== expWeCnt || obsWeData !== expWeData || obsWeTag !== expWeTag
             || (expWeCnt == 1 && obsWeSel !== expWeSel) || obsWeMulti !== 0) begin
            errors++; $display("[TB] FAIL rand%0d_we cnt=%0d wed=%b wet=%b sel=%b exp %0d/%b/%b/%b",
                               i, obsWeCnt, obsWeData, obsWeTag, obsWeSel, expWeCnt, expWeData, expWeTag, expWeSel);
         end
         checks++;
         if (obsReqCyc !== expReqCyc || (expReqCyc > 0 && (obsMemAddr !== expMemAddr || obsMemRw !== expMemRw))) begin
            errors++; $display("[TB] FAIL rand%0d_mem req=%0d addr=%h rw=%b exp %0d/%h/%b",
                               i, obsReqCyc, obsMemAddr, obsMemRw, expReqCyc, expMemAddr, expMemRw);
         end
         checks++;
         if (obsReCnt !== expReCnt || obsBusyBad !== 0) begin
            errors++; $display("[TB] FAIL rand%0d_seq re=%0d busybad=%0d exp %0d/0", i, obsReCnt, obsBusyBad, expReCnt);
         end
         checks++;
         if (hit_count !== 4'(expHits) || miss_count !== 4'(expMiss) || err !== expErr) begin
            errors++; $display("[TB] FAIL rand%0d_stats hc=%0d mc=%0d err=%b exp %0d/%0d/%b",
                               i, hit_count, miss_count, err, expHits, expMiss, expErr);
         end
      end
   endtask

   initial begin
      expHits = 0; expMiss = 0; expErr = 1'b0;
      test_reset();
      test_read_hit();
      test_read_miss();
      test_write_hit();
      test_write_miss();
      test_replay_err();
      test_reset_in_memrd();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
